// File: rtl/bc_param_cpu.sv
// Basic Computer accumulator CPU sequenced T0..T6, with memory-ref, register-ref, I/O and interrupt cycle.
// Latency: 5-7 cycles per memory-ref op, 4 per register/I-O op, 3 for the interrupt cycle.
// Backpressure: INPR accepted only while FGI=0 (in_ready), OUTR held while FGO=0 until out_ack.
module bc_param_cpu #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int IO_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic              in_valid,
    input  logic [IO_W-1:0]   in_data,
    output logic              in_ready,
    output logic [IO_W-1:0]   out_data,
    output logic              out_valid,
    input  logic              out_ack,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] ar,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] ac,
    output logic [DATA_W-1:0] dr,
    output logic              e,
    output logic              ien,
    output logic              halted
);

    typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6} sc_t;

    localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);
    localparam logic [DATA_W-1:0] D_ONE   = DATA_W'(1);
    localparam logic [DATA_W-1:0] IO_MASK = DATA_W'({IO_W{1'b1}});

    sc_t               sc_q, sc_d;
    logic [ADDR_W-1:0] pc_q, pc_d, ar_q, ar_d, tr_q, tr_d;
    logic [DATA_W-1:0] ir_q, ir_d, ac_q, ac_d, dr_q, dr_d;
    logic [IO_W-1:0]   outr_q, outr_d, inpr_q, inpr_d;
    logic              e_q, e_d, i_q, i_d, ien_q, ien_d, r_q, r_d;
    logic              fgi_q, fgi_d, fgo_q, fgo_d, halted_q, halted_d;

    logic [2:0]        opcode;
    logic              d7, rr_skip, io_skip;
    logic [DATA_W:0]   sum;

    assign opcode  = ir_q[DATA_W-2:DATA_W-4];
    assign d7      = (opcode == 3'd7);
    assign sum     = {1'b0, ac_q} + {1'b0, dr_q};
    assign rr_skip = (ir_q[4] & ~ac_q[DATA_W-1]) | (ir_q[3] & ac_q[DATA_W-1]) |
                     (ir_q[2] & (ac_q == '0)) | (ir_q[1] & ~e_q);
    assign io_skip = (ir_q[9] & fgi_q) | (ir_q[8] & fgo_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc_q     <= T0;
            pc_q     <= '0;
            ar_q     <= '0;
            tr_q     <= '0;
            ir_q     <= '0;
            ac_q     <= '0;
            dr_q     <= '0;
            outr_q   <= '0;
            inpr_q   <= '0;
            e_q      <= 1'b0;
            i_q      <= 1'b0;
            ien_q    <= 1'b0;
            r_q      <= 1'b0;
            fgi_q    <= 1'b0;
            fgo_q    <= 1'b1;
            halted_q <= 1'b0;
        end else begin
            sc_q     <= sc_d;
            pc_q     <= pc_d;
            ar_q     <= ar_d;
            tr_q     <= tr_d;
            ir_q     <= ir_d;
            ac_q     <= ac_d;
            dr_q     <= dr_d;
            outr_q   <= outr_d;
            inpr_q   <= inpr_d;
            e_q      <= e_d;
            i_q      <= i_d;
            ien_q    <= ien_d;
            r_q      <= r_d;
            fgi_q    <= fgi_d;
            fgo_q    <= fgo_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        sc_d     = sc_q;
        pc_d     = pc_q;
        ar_d     = ar_q;
        tr_d     = tr_q;
        ir_d     = ir_q;
        ac_d     = ac_q;
        dr_d     = dr_q;
        outr_d   = outr_q;
        inpr_d   = inpr_q;
        e_d      = e_q;
        i_d      = i_q;
        ien_d    = ien_q;
        r_d      = r_q;
        fgi_d    = fgi_q;
        fgo_d    = fgo_q;
        halted_d = halted_q;

        // Ack is applied first so that an OUT in the same cycle overrides it.
        if (out_ack && !fgo_q) fgo_d = 1'b1;

        if (!halted_q) begin
            if (r_q) begin
                unique case (sc_q)
                    T0:      begin ar_d = '0; tr_d = pc_q; sc_d = T1; end
                    T1:      begin pc_d = '0; sc_d = T2; end
                    T2:      begin pc_d = A_ONE; ien_d = 1'b0; r_d = 1'b0; sc_d = T0; end
                    default: sc_d = T0;
                endcase
            end else begin
                unique case (sc_q)
                    T0: begin ar_d = pc_q; sc_d = T1; end
                    T1: begin ir_d = mem_rdata; pc_d = pc_q + A_ONE; sc_d = T2; end
                    T2: begin ar_d = ir_q[ADDR_W-1:0]; i_d = ir_q[DATA_W-1]; sc_d = T3; end
                    T3: begin
                        if (d7 && !i_q) begin
                            // Every set bit acts on pre-cycle values; later bits win on conflict.
                            if (ir_q[11]) ac_d = '0;
                            if (ir_q[10]) e_d = 1'b0;
                            if (ir_q[9])  ac_d = ~ac_q;
                            if (ir_q[8])  e_d = ~e_q;
                            if (ir_q[7])  begin ac_d = {e_q, ac_q[DATA_W-1:1]}; e_d = ac_q[0]; end
                            if (ir_q[6])  begin ac_d = {ac_q[DATA_W-2:0], e_q}; e_d = ac_q[DATA_W-1]; end
                            if (ir_q[5])  ac_d = ac_q + D_ONE;
                            if (rr_skip)  pc_d = pc_q + A_ONE;
                            if (ir_q[0])  halted_d = 1'b1;
                            sc_d = T0;
                        end else if (d7) begin
                            if (ir_q[11]) begin ac_d = (ac_q & ~IO_MASK) | DATA_W'(inpr_q); fgi_d = 1'b0; end
                            if (ir_q[10]) begin outr_d = ac_q[IO_W-1:0]; fgo_d = 1'b0; end
                            if (io_skip)  pc_d = pc_q + A_ONE;
                            if (ir_q[7])  ien_d = 1'b1;
                            if (ir_q[6])  ien_d = 1'b0;
                            sc_d = T0;
                        end else begin
                            if (i_q) ar_d = mem_rdata[ADDR_W-1:0];
                            sc_d = T4;
                        end
                    end
                    T4: begin
                        unique case (opcode)
                            3'd0, 3'd1, 3'd2, 3'd6: begin dr_d = mem_rdata; sc_d = T5; end
                            3'd4:    begin pc_d = ar_q; sc_d = T0; end
                            3'd5:    begin ar_d = ar_q + A_ONE; sc_d = T5; end
                            default: sc_d = T0;
                        endcase
                    end
                    T5: begin
                        sc_d = T0;
                        unique case (opcode)
                            3'd0:    ac_d = ac_q & dr_q;
                            3'd1:    {e_d, ac_d} = sum;
                            3'd2:    ac_d = dr_q;
                            3'd5:    pc_d = ar_q;
                            3'd6:    begin dr_d = dr_q + D_ONE; sc_d = T6; end
                            default: sc_d = T0;
                        endcase
                    end
                    T6: begin
                        if (dr_q == '0) pc_d = pc_q + A_ONE;
                        sc_d = T0;
                    end
                    default: sc_d = T0;
                endcase

                if (sc_q != T0 && sc_q != T1 && sc_q != T2 && ien_q && (fgi_q || fgo_q))
                    r_d = 1'b1;
            end
        end

        // An accepted character beats an INP clear landing in the same cycle.
        if (in_valid && !fgi_q) begin
            inpr_d = in_data;
            fgi_d  = 1'b1;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (!halted_q) begin
            if (r_q) begin
                if (sc_q == T1) begin mem_we = 1'b1; mem_wdata = DATA_W'(tr_q); end
            end else if (sc_q == T4 && opcode == 3'd3) begin
                mem_we = 1'b1; mem_wdata = ac_q;
            end else if (sc_q == T4 && opcode == 3'd5) begin
                mem_we = 1'b1; mem_wdata = DATA_W'(pc_q);
            end else if (sc_q == T6 && opcode == 3'd6) begin
                mem_we = 1'b1; mem_wdata = dr_q;
            end
        end
    end

    assign mem_addr  = ar_q;
    assign in_ready  = ~fgi_q;
    assign out_valid = ~fgo_q;
    assign out_data  = outr_q;
    assign pc        = pc_q;
    assign ar        = ar_q;
    assign ir        = ir_q;
    assign ac        = ac_q;
    assign dr        = dr_q;
    assign e         = e_q;
    assign ien       = ien_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_bc_param_cpu.sv
// Bench for bc_param_cpu: register-ref vector table, directed multi-cycle sequences,
// and a random instruction stream checked against an instruction-level model.
module tb_bc_param_cpu;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata, mem_wdata;
    logic          mem_we;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_data = '0;
    logic          in_ready;
    logic [IW-1:0] out_data;
    logic          out_valid;
    logic          out_ack = 1'b0;
    logic [AW-1:0] pc, ar;
    logic [DW-1:0] ir, ac, dr;
    logic          e, ien, halted;

    logic [DW-1:0] mem [0:4095];
    logic [DW-1:0] rm  [0:4095];

    int n_vec = 0;
    int n_bad = 0;

    bc_param_cpu #(.ADDR_W(AW), .DATA_W(DW), .IO_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ack(out_ack),
        .pc(pc), .ar(ar), .ir(ir), .ac(ac), .dr(dr),
        .e(e), .ien(ien), .halted(halted)
    );

    assign mem_rdata = mem[mem_addr];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock; the memory model commits a write sampled before the edge.
    task automatic tick();
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        we = mem_we; wa = mem_addr; wd = mem_wdata;
        @(posedge clk);
        #1;
        if (we) mem[wa] = wd;
    endtask

    task automatic enter_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ack = 1'b0; in_data = '0;
        @(posedge clk); #1;
        for (int a = 0; a < 4096; a++) mem[a] = '0;
    endtask

    task automatic leave_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic run_until_halt(input string name, input int budget);
        int k = 0;
        while (!halted && k < budget) begin tick(); k++; end
        chk(name, halted, 1);
    endtask

    typedef struct {
        logic [DW-1:0] ac_in;
        logic          e_in;
        logic [DW-1:0] instr;
        logic [DW-1:0] ac_exp;
        logic          e_exp;
        logic [AW-1:0] pc_exp;
    } rvec_t;

    rvec_t tv [12];

    initial begin
        logic [DW-1:0] instr, a0;
        logic [AW-1:0] m_pc, pcn, ea, adr;
        logic [DW-1:0] m_ac;
        logic          m_e, e0, skp;
        logic [2:0]    op;
        int            cyc, cat, sel, md;
        logic [11:0]   bits;

        tv[0]  = '{16'h1234, 1'b0, 16'h7800, 16'h0000, 1'b0, 12'd4};
        tv[1]  = '{16'h1234, 1'b1, 16'h7400, 16'h1234, 1'b0, 12'd4};
        tv[2]  = '{16'h1234, 1'b0, 16'h7200, 16'hEDCB, 1'b0, 12'd4};
        tv[3]  = '{16'h8001, 1'b0, 16'h7080, 16'h4000, 1'b1, 12'd4};
        tv[4]  = '{16'h8001, 1'b0, 16'h7040, 16'h0002, 1'b1, 12'd4};
        tv[5]  = '{16'hFFFF, 1'b0, 16'h7020, 16'h0000, 1'b0, 12'd4};
        tv[6]  = '{16'h0000, 1'b1, 16'h7006, 16'h0000, 1'b1, 12'd5};
        tv[7]  = '{16'h8000, 1'b0, 16'h701A, 16'h8000, 1'b0, 12'd5};
        tv[8]  = '{16'h0001, 1'b1, 16'h7010, 16'h0001, 1'b1, 12'd5};
        tv[9]  = '{16'h7FFF, 1'b0, 16'h7008, 16'h7FFF, 1'b0, 12'd4};
        tv[10] = '{16'h00FF, 1'b1, 16'h7204, 16'hFF00, 1'b1, 12'd4};
        tv[11] = '{16'h0000, 1'b0, 16'h7102, 16'h0000, 1'b1, 12'd5};

        enter_reset();
        chk("rst_pc", pc, 0);   chk("rst_ac", ac, 0);   chk("rst_ir", ir, 0);
        chk("rst_e", e, 0);     chk("rst_ien", ien, 0); chk("rst_halted", halted, 0);
        chk("rst_in_ready", in_ready, 1); chk("rst_out_valid", out_valid, 0);
        chk("rst_mem_we", mem_we, 0);

        // Register-reference table: LDA sets AC, CLE/CME sets E, then the vector instruction.
        for (int i = 0; i < 12; i++) begin
            enter_reset();
            mem[0] = 16'h2800; mem[12'h800] = tv[i].ac_in;
            mem[1] = 16'h7400; mem[2] = tv[i].e_in ? 16'h7100 : 16'h7000;
            mem[3] = tv[i].instr;
            leave_reset();
            repeat (18) tick();
            chk($sformatf("rr%0d_ac", i), ac, tv[i].ac_exp);
            chk($sformatf("rr%0d_e", i), e, tv[i].e_exp);
            chk($sformatf("rr%0d_pc", i), pc, tv[i].pc_exp);
        end

        // LDA/ADD/STA/HLT.
        enter_reset();
        mem[0] = 16'h2004; mem[1] = 16'h1005; mem[2] = 16'h3006; mem[3] = 16'h7001;
        mem[4] = 16'hFFFF; mem[5] = 16'h0002;
        leave_reset();
        run_until_halt("prog1_halt", 60);
        chk("prog1_m6", mem[6], 16'h0001); chk("prog1_e", e, 1);
        chk("prog1_pc", pc, 4);            chk("prog1_ac", ac, 16'h0001);
        repeat (5) tick();
        chk("prog1_frozen_pc", pc, 4);

        // Indirect LDA takes six cycles.
        enter_reset();
        mem[0] = 16'hA010; mem[12'h10] = 16'h0020; mem[12'h20] = 16'h1234;
        leave_reset();
        repeat (5) tick();
        chk("ind_ac_early", ac, 0);
        tick();
        chk("ind_ac", ac, 16'h1234);

        // ISZ wrap with skip, then BSA.
        enter_reset();
        mem[0] = 16'h6007; mem[7] = 16'hFFFF; mem[2] = 16'h5030;
        leave_reset();
        repeat (7) tick();
        chk("isz_m7", mem[7], 0); chk("isz_pc", pc, 2);
        repeat (6) tick();
        chk("bsa_m30", mem[12'h30], 16'h0003); chk("bsa_pc", pc, 12'h031);

        // Input handshake then INP keeps the upper AC byte.
        enter_reset();
        mem[0] = 16'h2010; mem[12'h10] = 16'hAB00; mem[1] = 16'hF800; mem[2] = 16'h7001;
        leave_reset();
        in_valid = 1'b1; in_data = 8'h41;
        tick();
        chk("inp_ready_low", in_ready, 0);
        in_data = 8'h99;
        tick();
        in_valid = 1'b0;
        run_until_halt("inp_halt", 40);
        chk("inp_ac", ac, 16'hAB41); chk("inp_ready_back", in_ready, 1);

        // OUT, OUT colliding with ack, then plain acks.
        enter_reset();
        mem[0] = 16'h2010; mem[12'h10] = 16'h0055; mem[1] = 16'hF400; mem[2] = 16'hF400;
        mem[3] = 16'h7001;
        leave_reset();
        repeat (10) tick();
        chk("out_valid", out_valid, 1); chk("out_data", out_data, 8'h55);
        repeat (3) tick();
        out_ack = 1'b1; tick(); out_ack = 1'b0;
        chk("out_collide_valid", out_valid, 1);
        run_until_halt("out_halt", 20);
        repeat (3) tick();
        chk("out_hold", out_valid, 1);
        out_ack = 1'b1; tick();
        chk("out_acked", out_valid, 0);
        tick(); out_ack = 1'b0;
        chk("out_ack_idle", out_valid, 0);

        // ION, next instruction completes, then the interrupt cycle.
        enter_reset();
        mem[0] = 16'hF080; mem[1] = 16'h7020;
        leave_reset();
        repeat (4) tick();
        chk("ion_ien", ien, 1);
        in_valid = 1'b1; in_data = 8'h33;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("irq_pre_pc", pc, 2); chk("irq_pre_ac", ac, 1);
        repeat (3) tick();
        chk("irq_m0", mem[0], 16'h0002); chk("irq_pc", pc, 1); chk("irq_ien", ien, 0);

        // Reset during STA T4 suppresses the write.
        enter_reset();
        mem[0] = 16'h2010; mem[12'h10] = 16'h5A5A; mem[1] = 16'h3020; mem[12'h20] = 16'h1111;
        leave_reset();
        repeat (10) tick();
        chk("sta_we_armed", mem_we, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_we", mem_we, 0);
        tick();
        chk("abort_mem", mem[12'h20], 16'h1111);
        chk("abort_pc", pc, 0); chk("abort_ac", ac, 0); chk("abort_ar", ar, 0);
        chk("abort_ir", ir, 0); chk("abort_dr", dr, 0);

        // Random instruction stream against an instruction-level model.
        enter_reset();
        for (int a = 0; a < 32; a++) mem[12'h800 + a] = 16'($urandom);
        for (int a = 0; a < 8; a++)  mem[12'h900 + a] = 16'h0800 + 16'($urandom_range(0, 31));
        for (int a = 0; a < 4096; a++) rm[a] = mem[a];
        m_pc = '0; m_ac = '0; m_e = 1'b0;
        leave_reset();
        for (int n = 0; n < 300; n++) begin
            cat = $urandom_range(0, 8);
            if (m_pc >= 12'h700) begin
                instr = 16'h4100;
            end else if (cat <= 6) begin
                if (cat == 4 || cat == 5)
                    instr = {1'b0, 3'(cat), 12'($urandom_range(12'h100, 12'h5FF))};
                else if ($urandom_range(0, 1) == 1)
                    instr = {1'b1, 3'(cat), 12'h900 + 12'($urandom_range(0, 7))};
                else
                    instr = {1'b0, 3'(cat), 12'h800 + 12'($urandom_range(0, 31))};
            end else if (cat == 7) begin
                md = $urandom_range(0, 7);
                bits = 12'($urandom_range(0, 15)) << 1;
                if (md < 7) bits = bits | (12'h800 >> md);
                instr = {4'h7, bits};
            end else begin
                sel = $urandom_range(0, 2);
                instr = {4'hF, (sel == 0) ? 12'h200 : (sel == 1) ? 12'h100 : 12'h040};
            end
            mem[m_pc] = instr; rm[m_pc] = instr;

            op = instr[14:12]; adr = instr[11:0]; pcn = m_pc + 12'd1;
            a0 = m_ac; e0 = m_e; cyc = 4;
            if (op != 3'd7) begin
                ea = instr[15] ? rm[adr][11:0] : adr;
                case (op)
                    3'd0: begin m_ac = a0 & rm[ea]; cyc = 6; end
                    3'd1: begin {m_e, m_ac} = {1'b0, a0} + {1'b0, rm[ea]}; cyc = 6; end
                    3'd2: begin m_ac = rm[ea]; cyc = 6; end
                    3'd3: begin rm[ea] = a0; cyc = 5; end
                    3'd4: begin pcn = ea; cyc = 5; end
                    3'd5: begin rm[ea] = {4'h0, pcn}; pcn = ea + 12'd1; cyc = 6; end
                    default: begin
                        rm[ea] = rm[ea] + 16'd1;
                        if (rm[ea] == 16'd0) pcn = pcn + 12'd1;
                        cyc = 7;
                    end
                endcase
            end else if (!instr[15]) begin
                if (instr[11]) m_ac = 16'h0000;
                if (instr[10]) m_e = 1'b0;
                if (instr[9])  m_ac = ~a0;
                if (instr[8])  m_e = ~e0;
                if (instr[7])  begin m_ac = {e0, a0[15:1]}; m_e = a0[0]; end
                if (instr[6])  begin m_ac = {a0[14:0], e0}; m_e = a0[15]; end
                if (instr[5])  m_ac = a0 + 16'd1;
                skp = (instr[4] && !a0[15]) || (instr[3] && a0[15]) ||
                      (instr[2] && a0 == 0) || (instr[1] && !e0);
                if (skp) pcn = pcn + 12'd1;
            end else begin
                if (instr[8]) pcn = pcn + 12'd1;
            end
            m_pc = pcn;
            repeat (cyc) tick();
            chk($sformatf("rnd%0d_pc", n), pc, m_pc);
            chk($sformatf("rnd%0d_ac", n), ac, m_ac);
            chk($sformatf("rnd%0d_e", n), e, m_e);
        end
        for (int a = 0; a < 32; a++)
            chk($sformatf("rnd_mem%0d", a), mem[12'h800 + a], rm[12'h800 + a]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
